// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] DEF_LAST_PC  = 32'h0040_0400;

  // Control-transfer kind resolved by decode.
  typedef enum logic [1:0] {
    KIND_BR   = 2'b00,
    KIND_J    = 2'b01,
    KIND_JR   = 2'b10,
    KIND_RSVD = 2'b11
  } redirect_kind_e;

  // Fetch sequencing state.
  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_e;

  // Branch offset is in words: sign-extend and convert to a byte offset.
  function automatic logic [31:0] word_offset_bytes(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory, hazard/redirect controls and IF/ID outputs.
interface fetch_stage_if
  import fetch_stage_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  logic [31:0]        imem_pc;
  logic [INSTR_W-1:0] imem_instr;
  logic               stall;
  logic               redirect_valid;
  logic [1:0]         redirect_kind;
  logic [15:0]        branch_imm;
  logic [25:0]        jump_target;
  logic [31:0]        jr_addr;
  logic               halt_req;
  logic               ifid_valid;
  logic [INSTR_W-1:0] ifid_instr;
  logic [31:0]        ifid_pc_plus4;
  logic               fetch_fault;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  // The fetch stage itself.
  modport master (
    output imem_pc,
    input  imem_instr,
    input  stall,
    input  redirect_valid,
    input  redirect_kind,
    input  branch_imm,
    input  jump_target,
    input  jr_addr,
    input  halt_req,
    output ifid_valid,
    output ifid_instr,
    output ifid_pc_plus4,
    output fetch_fault,
    output halted,
    output fetch_count
  );

  // Memory, hazard unit and decode seen from the other side.
  modport slave (
    input  imem_pc,
    output imem_instr,
    output stall,
    output redirect_valid,
    output redirect_kind,
    output branch_imm,
    output jump_target,
    output jr_addr,
    output halt_req,
    input  ifid_valid,
    input  ifid_instr,
    input  ifid_pc_plus4,
    input  fetch_fault,
    input  halted,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_stage_next_pc_calc.sv
// Combinational redirect target computation with alignment and kind checks.
module next_pc_calc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] base,
  input  logic [1:0]  kind,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_addr,
  output logic [31:0] target,
  output logic        target_bad
);

  // Select the target by kind; reserved kind and misaligned targets are illegal.
  always_comb begin
    target     = base;
    target_bad = 1'b0;
    case (kind)
      KIND_BR:  target = base + word_offset_bytes(branch_imm);
      KIND_J:   target = {base[31:28], jump_target, 2'b00};
      KIND_JR:  target = jr_addr;
      default:  target_bad = 1'b1;
    endcase
    if (target[1:0] != 2'b00) begin
      target_bad = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, fault detection and
// a saturating count of instructions captured into IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] LAST_PC  = DEF_LAST_PC,
  parameter int          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  fetch_state_e       state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;
  logic               ifid_valid_reg, ifid_valid_next;
  logic [INSTR_W-1:0] ifid_instr_reg, ifid_instr_next;
  logic [31:0]        ifid_pc_plus4_reg, ifid_pc_plus4_next;
  logic               fault_reg, fault_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  logic [31:0] pc_plus4;
  logic        pc_in_range;
  logic        redirect_take;
  logic [31:0] redirect_target;
  logic        redirect_bad;

  // Redirect base is the PC+4 of the control instruction now sitting in IF/ID.
  next_pc_calc u_next_pc_calc (
    .base        (ifid_pc_plus4_reg),
    .kind        (bus.redirect_kind),
    .branch_imm  (bus.branch_imm),
    .jump_target (bus.jump_target),
    .jr_addr     (bus.jr_addr),
    .target      (redirect_target),
    .target_bad  (redirect_bad)
  );

  assign pc_plus4      = pc_reg + 32'd4;
  assign pc_in_range   = (pc_reg >= RESET_PC) && (pc_reg <= LAST_PC);
  // A redirect with nothing live in IF/ID has no valid base and is dropped.
  assign redirect_take = bus.redirect_valid && ifid_valid_reg;

  // Next-state and datapath update, priority halt > redirect > stall > sequential.
  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    ifid_valid_next    = ifid_valid_reg;
    ifid_instr_next    = ifid_instr_reg;
    ifid_pc_plus4_next = ifid_pc_plus4_reg;
    fault_next         = fault_reg;
    count_next         = count_reg;
    case (state_reg)
      ST_BOOT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          ifid_valid_next = 1'b0;
          state_next      = ST_HALT;
        end else if (redirect_take) begin
          ifid_valid_next = 1'b0;
          if (redirect_bad) begin
            fault_next = 1'b1;
            state_next = ST_HALT;
          end else begin
            pc_next = redirect_target;
          end
        end else if (bus.stall) begin
          // hold everything
        end else if (!pc_in_range) begin
          fault_next      = 1'b1;
          ifid_valid_next = 1'b0;
          state_next      = ST_HALT;
        end else begin
          pc_next            = pc_plus4;
          ifid_valid_next    = 1'b1;
          ifid_instr_next    = bus.imem_instr;
          ifid_pc_plus4_next = pc_plus4;
          if (count_reg != {CNT_W{1'b1}}) begin
            count_next = count_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        ifid_valid_next = 1'b0;
        state_next      = ST_HALT;
      end
    endcase
  end

  // State and datapath registers; reset restores the boot PC immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_BOOT;
      pc_reg            <= RESET_PC;
      ifid_valid_reg    <= 1'b0;
      ifid_instr_reg    <= '0;
      ifid_pc_plus4_reg <= '0;
      fault_reg         <= 1'b0;
      count_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      ifid_valid_reg    <= ifid_valid_next;
      ifid_instr_reg    <= ifid_instr_next;
      ifid_pc_plus4_reg <= ifid_pc_plus4_next;
      fault_reg         <= fault_next;
      count_reg         <= count_next;
    end
  end

  assign bus.imem_pc       = pc_reg;
  assign bus.ifid_valid    = ifid_valid_reg;
  assign bus.ifid_instr    = ifid_instr_reg;
  assign bus.ifid_pc_plus4 = ifid_pc_plus4_reg;
  assign bus.fetch_fault   = fault_reg;
  assign bus.halted        = (state_reg == ST_HALT);
  assign bus.fetch_count   = count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 4-bit fetch counter so saturation is reachable.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   edge_no;

  fetch_stage_if #(.CNT_W(4)) bus ();

  fetch_stage #(.CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory model: word content derived from its address.
  assign bus.imem_instr = bus.imem_pc ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_kind  = 2'b00;
    bus.branch_imm     = 16'h0000;
    bus.jump_target    = 26'h0;
    bus.jr_addr        = 32'h0;
    bus.halt_req       = 1'b0;
  endtask

  // One clock edge with the currently driven inputs; inputs return to idle after.
  task automatic tick(input string what);
    @(posedge clk);
    @(negedge clk);
    edge_no++;
    $display("[TB] edge %0d %s: pc=%08h v=%0b plus4=%08h cnt=%0d flt=%0b hlt=%0b",
             edge_no, what, bus.imem_pc, bus.ifid_valid, bus.ifid_pc_plus4,
             bus.fetch_count, bus.fetch_fault, bus.halted);
    idle();
  endtask

  // After a sequential capture: new pc, IF/ID holds the word fetched at pc-4.
  task automatic expect_run(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    check({tag, ".pc"},    bus.imem_pc, pc);
    check({tag, ".valid"}, 32'(bus.ifid_valid), 32'd1);
    check({tag, ".plus4"}, bus.ifid_pc_plus4, pc);
    check({tag, ".instr"}, bus.ifid_instr, (pc - 32'd4) ^ KEY);
    check({tag, ".count"}, 32'(bus.fetch_count), cnt);
    check({tag, ".fault"}, 32'(bus.fetch_fault), 32'd0);
    check({tag, ".halted"}, 32'(bus.halted), 32'd0);
  endtask

  // IF/ID empty (squash, boot, halt or fault).
  task automatic expect_empty(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                              input logic flt, input logic hlt);
    check({tag, ".pc"},     bus.imem_pc, pc);
    check({tag, ".valid"},  32'(bus.ifid_valid), 32'd0);
    check({tag, ".count"},  32'(bus.fetch_count), cnt);
    check({tag, ".fault"},  32'(bus.fetch_fault), 32'(flt));
    check({tag, ".halted"}, 32'(bus.halted), 32'(hlt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic redirect(input logic [1:0] kind, input logic [15:0] imm,
                          input logic [25:0] tgt, input logic [31:0] jr);
    bus.redirect_valid = 1'b1;
    bus.redirect_kind  = kind;
    bus.branch_imm     = imm;
    bus.jump_target    = tgt;
    bus.jr_addr        = jr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    edge_no      = 0;
    rst_n        = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    expect_empty("reset", 32'h0040_0000, 0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // BOOT edge captures nothing.
    tick("boot");
    expect_empty("boot", 32'h0040_0000, 0, 1'b0, 1'b0);

    // Three sequential fetches.
    tick("seq1"); expect_run("seq1", 32'h0040_0004, 1);
    tick("seq2"); expect_run("seq2", 32'h0040_0008, 2);
    tick("seq3"); expect_run("seq3", 32'h0040_000C, 3);

    // Two stall cycles hold everything, then resume at the same PC.
    bus.stall = 1'b1; tick("stall1");
    bus.stall = 1'b1; tick("stall2");
    expect_run("stall", 32'h0040_000C, 3);
    tick("resume"); expect_run("resume", 32'h0040_0010, 4);

    // BR backward by two words from base 0x00400010.
    redirect(2'b00, 16'hFFFE, 26'h0, 32'h0);
    tick("br");
    expect_empty("br", 32'h0040_0008, 4, 1'b0, 1'b0);

    // Redirect with IF/ID empty is ignored: plain sequential fetch.
    redirect(2'b01, 16'h0, 26'h3FF_FFFF, 32'h0);
    tick("ign");
    expect_run("ign", 32'h0040_000C, 5);

    for (int i = 0; i < 5; i++) tick("seq");
    expect_run("seq8", 32'h0040_0020, 10);

    // J from base 0x00400020.
    redirect(2'b01, 16'h0, 26'h010_0004, 32'h0);
    tick("j");
    expect_empty("j", 32'h0040_0010, 10, 1'b0, 1'b0);

    tick("seq"); expect_run("seqj", 32'h0040_0014, 11);

    // JR wins over simultaneous stall.
    redirect(2'b10, 16'h0, 26'h0, 32'h0040_0100);
    bus.stall = 1'b1;
    tick("jr_stall");
    expect_empty("jr_stall", 32'h0040_0100, 11, 1'b0, 1'b0);

    tick("seq"); expect_run("seqjr", 32'h0040_0104, 12);

    // Misaligned JR target faults at this edge.
    redirect(2'b10, 16'h0, 26'h0, 32'h0040_0002);
    tick("jr_misal");
    expect_empty("misal", 32'h0040_0104, 12, 1'b1, 1'b1);

    // Halted: further stimulus is ignored.
    redirect(2'b10, 16'h0, 26'h0, 32'h0040_0200);
    tick("ignored");
    tick("ignored");
    expect_empty("halt_ign", 32'h0040_0104, 12, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle takes effect before the next edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 expect_empty("async_rst", 32'h0040_0000, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("boot");
    tick("seq"); expect_run("r2seq", 32'h0040_0004, 1);

    // Out-of-range JR target: accepted, then faults at the following fetch edge.
    redirect(2'b10, 16'h0, 26'h0, 32'h0050_0000);
    tick("jr_far");
    expect_empty("far", 32'h0050_0000, 1, 1'b0, 1'b0);
    tick("far_fetch");
    expect_empty("far_flt", 32'h0050_0000, 1, 1'b1, 1'b1);

    // LAST_PC itself is fetchable; one word past it faults.
    do_reset();
    tick("boot");
    tick("seq");
    redirect(2'b10, 16'h0, 26'h0, 32'h0040_0400);
    tick("jr_last");
    tick("fetch_last"); expect_run("last", 32'h0040_0404, 2);
    tick("past_last");
    expect_empty("past", 32'h0040_0404, 2, 1'b1, 1'b1);

    // Reserved kind faults.
    do_reset();
    tick("boot");
    tick("seq");
    redirect(2'b11, 16'h0, 26'h0, 32'h0040_0100);
    tick("rsvd");
    expect_empty("rsvd", 32'h0040_0004, 1, 1'b1, 1'b1);

    // Counter saturates at 15, then halt_req beats a simultaneous redirect.
    do_reset();
    tick("boot");
    for (int i = 0; i < 17; i++) tick("seq");
    expect_run("sat", 32'h0040_0044, 15);
    bus.halt_req = 1'b1;
    redirect(2'b10, 16'h0, 26'h0, 32'h0040_0100);
    tick("halt");
    expect_empty("halt", 32'h0040_0044, 15, 1'b0, 1'b1);
    tick("halted");
    expect_empty("halted", 32'h0040_0044, 15, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
